// File: rtl/fifo_drain.sv
// Drains a one-cycle-latency FIFO into a ready/valid stream through a 2-word skid buffer,
// tagging the last word of every PKT_LEN-word packet.
module fifo_drain #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned PKT_LEN = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_rddata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
);

  localparam int unsigned     CntW    = $clog2(PKT_LEN);
  localparam logic [CntW-1:0] LastIdx = CntW'(PKT_LEN - 1);

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pop;
  logic [1:0]       load;
  logic [1:0]       slot;

  assign m_valid = rst_n && (occ_q != 2'd0);
  assign pop     = m_valid && m_ready;
  // occ + inflight is bounded by 2 and pop implies occ >= 1, so these never wrap
  assign load    = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign slot    = occ_q - {1'b0, pop};

  assign fifo_rden = rst_n && !fifo_empty && (load < 2'd2);
  assign m_data    = head_q;
  assign m_last    = m_valid && (cnt_q == LastIdx);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = load;
    cnt_d  = cnt_q;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = (cnt_q == LastIdx) ? '0 : cnt_q + CntW'(1);
    end
    // The in-flight word lands in the first free slot after this cycle's pop
    if (inflight_q) begin
      if (slot == 2'd0) begin
        head_d = fifo_rddata;
      end else begin
        tail_d = fifo_rddata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rden;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: directed scenarios then random traffic, checked against a queue model
// of words read from the upstream FIFO and not yet delivered downstream.
module tb_fifo_drain;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned PKT_LEN = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty = 1'b1;
  logic             fifo_rden;
  logic [WIDTH-1:0] fifo_rddata = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  fifo_drain #(
    .WIDTH  (WIDTH),
    .PKT_LEN(PKT_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rden  (fifo_rden),
    .fifo_rddata(fifo_rddata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model state: every word read upstream and not yet popped, oldest first
  logic [WIDTH-1:0] exp_q[$];
  int               pkt_idx = 0;
  bit               inflight = 0;
  int               reads = 0;
  bit               use_seq = 1;
  logic [WIDTH-1:0] seq = '0;
  logic [WIDTH-1:0] last_word = '0;

  // Observations from the most recent cycle
  logic             o_rden, o_valid, o_last, o_pop;
  logic [WIDTH-1:0] o_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit empty, input bit ready);
    bit exp_valid, exp_rden, pop, rd;
    int vis;
    rst_n      = rst;
    fifo_empty = empty;
    m_ready    = ready;
    @(negedge clk);
    o_rden  = fifo_rden;
    o_valid = m_valid;
    o_data  = m_data;
    o_last  = m_last;
    pop     = 1'b0;
    if (!rst) begin
      check("rst_rden", 64'(o_rden), 64'd0);
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_last", 64'(o_last), 64'd0);
    end else begin
      vis       = exp_q.size() - int'(inflight);
      exp_valid = vis > 0;
      check("valid", 64'(o_valid), 64'(exp_valid));
      if (exp_valid) begin
        check("data", 64'(o_data), 64'(exp_q[0]));
        check("last", 64'(o_last), 64'(pkt_idx == PKT_LEN - 1));
      end else begin
        check("last_idle", 64'(o_last), 64'd0);
      end
      pop      = exp_valid && ready;
      exp_rden = !empty && ((exp_q.size() - int'(pop)) < 2);
      check("rden", 64'(o_rden), 64'(exp_rden));
    end
    o_pop = pop;
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      pkt_idx  = 0;
      inflight = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        pkt_idx = (pkt_idx + 1) % PKT_LEN;
      end
      rd = o_rden && !empty;
      if (rd) begin
        last_word = use_seq ? seq : WIDTH'($urandom);
        seq       = seq + 1'b1;
        exp_q.push_back(last_word);
        reads++;
      end
      inflight = rd;
    end
    #1;
    fifo_rddata = inflight ? last_word : WIDTH'($urandom);
  endtask

  initial begin
    bit               lastv[16];
    logic [WIDTH-1:0] held;
    int               pops;

    // Reset held for 2 clocks with data available upstream
    cycle(0, 0, 0);
    cycle(0, 0, 0);

    // Single word 0xA5
    seq = 16'h00A5;
    cycle(1, 0, 1);
    check("single_rden_c0", 64'(o_rden), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 1, 1);
      check($sformatf("single_valid_c%0d", i), 64'(o_valid), 64'(i == 2));
      if (i == 2) check("single_data", 64'(o_data), 64'hA5);
    end

    // Stream 0..7 at full rate
    cycle(0, 1, 0);
    seq   = '0;
    reads = 0;
    for (int c = 0; c < 14; c++) begin
      cycle(1, c >= 8, 1);
      if (c >= 2 && c <= 9) begin
        check($sformatf("stream_valid_c%0d", c), 64'(o_valid), 64'd1);
        check($sformatf("stream_data_c%0d", c), 64'(o_data), 64'(c - 2));
      end
    end
    check("stream_reads", 64'(reads), 64'd8);

    // Backpressure for 5 cycles, then recovery
    cycle(0, 1, 0);
    for (int c = 0; c < 6; c++) cycle(1, 0, 1);
    cycle(1, 0, 0);
    held = o_data;
    for (int c = 1; c < 5; c++) begin
      cycle(1, 0, 0);
      check("bp_held", 64'(o_data), 64'(held));
      check("bp_outstanding", 64'(exp_q.size() <= 2), 64'd1);
    end
    for (int c = 0; c < 8; c++) cycle(1, 0, 1);
    for (int c = 0; c < 4; c++) cycle(1, 1, 1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Packets of 4, 10 words
    cycle(0, 1, 0);
    seq = '0;
    for (int c = 0; c < 16; c++) begin
      cycle(1, c >= 10, 1);
      if (o_pop) lastv[o_data[3:0]] = o_last;
    end
    check("pkt_last_w3", 64'(lastv[3]), 64'd1);
    check("pkt_last_w7", 64'(lastv[7]), 64'd1);
    check("pkt_last_w9", 64'(lastv[9]), 64'd0);
    check("pkt_last_w2", 64'(lastv[2]), 64'd0);

    // Mid-stream reset with the buffer full
    for (int c = 0; c < 4; c++) cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 1, 0);
    check("midrst_valid", 64'(o_valid), 64'd0);

    // Restart: first popped word is packet index 0
    seq  = 16'd100;
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      cycle(1, c >= 5, 1);
      if (o_pop) begin
        check($sformatf("restart_last_p%0d", pops), 64'(o_last), 64'(pops == 3));
        pops++;
      end
    end
    check("restart_pops", 64'(pops), 64'd5);

    // Random traffic with occasional resets
    use_seq = 0;
    for (int c = 0; c < 800; c++) begin
      cycle($urandom_range(99) != 0, $urandom_range(2) == 0, $urandom_range(3) != 0);
    end
    for (int c = 0; c < 6; c++) cycle(1, 1, 1);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
